// File: rtl/threshold_ctrl_if.sv
// Request/response bundle between the key/remote sources and the threshold controller.
interface threshold_ctrl_if;
    logic       key_flag;
    logic [1:0] key_value;
    logic       key_hold;
    logic       rem_valid;
    logic [3:0] rem_grade;
    logic       rem_ready;
    logic [3:0] thr_grade;
    logic [7:0] threshold;
    logic       thr_upd;

    modport master (
        output key_flag, key_value, key_hold, rem_valid, rem_grade,
        input  rem_ready, thr_grade, threshold, thr_upd
    );

    modport slave (
        input  key_flag, key_value, key_hold, rem_valid, rem_grade,
        output rem_ready, thr_grade, threshold, thr_upd
    );
endinterface

// File: rtl/threshold_ctrl.sv
// Alarm-threshold controller: arbitrates local keys (with long-press auto-repeat)
// against remote grade requests and drives a registered threshold with update strobe.
module threshold_ctrl #(
    parameter int REPEAT_DLY = 50000000,
    parameter int REPEAT_PER = 10000000,
    parameter int GRADE_RST  = 9,
    parameter int GRADE_MAX  = 15,
    parameter int STEP       = 10
) (
    input  logic             clk,
    input  logic             rst,
    threshold_ctrl_if.slave  bus
);

    localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int CNT_W   = ($clog2(CNT_MAX) > 26) ? $clog2(CNT_MAX) : 26;
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);

    typedef enum logic [1:0] {IDLE, HOLD_DLY, REPEAT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [3:0]       grade_q, grade_d;
    logic [7:0]       thr_q, thr_d;
    logic             upd_q;
    logic             key_press;
    logic             rem_ready;

    function automatic logic [3:0] step_grade(input logic [3:0] g, input logic up);
        if (up) return (int'(g) >= GRADE_MAX) ? g : g + 4'd1;
        return (g == 4'd0) ? g : g - 4'd1;
    endfunction

    function automatic logic [3:0] clamp_grade(input logic [3:0] g);
        return (int'(g) > GRADE_MAX) ? 4'(GRADE_MAX) : g;
    endfunction

    function automatic logic [7:0] calc_thr(input logic [3:0] g);
        return 8'((int'(g) + 1) * STEP);
    endfunction

    assign key_press = bus.key_flag && (bus.key_value == 2'b01 || bus.key_value == 2'b10);
    // Local keys always win: a key pulse blocks the remote even if it carries no step.
    assign rem_ready = (state_q == IDLE) && !bus.key_flag;
    assign thr_d     = calc_thr(grade_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        grade_d = grade_q;
        if (key_press) begin
            dir_d   = (bus.key_value == 2'b10);
            grade_d = step_grade(grade_q, dir_d);
            state_d = HOLD_DLY;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.rem_valid && rem_ready) grade_d = clamp_grade(bus.rem_grade);
                end
                HOLD_DLY: begin
                    if (!bus.key_hold) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DLY_LAST) begin
                        grade_d = step_grade(grade_q, dir_q);
                        state_d = REPEAT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (!bus.key_hold) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == PER_LAST) begin
                        grade_d = step_grade(grade_q, dir_q);
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            grade_q <= 4'(GRADE_RST);
            thr_q   <= calc_thr(4'(GRADE_RST));
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            grade_q <= grade_d;
            thr_q   <= thr_d;
            upd_q   <= (thr_d != thr_q);
        end
    end

    assign bus.rem_ready = rem_ready;
    assign bus.thr_grade = grade_q;
    assign bus.threshold = thr_q;
    assign bus.thr_upd   = upd_q;

endmodule

// File: doc/threshold_ctrl.md
Name: threshold_ctrl

Overview:
Configuration controller for the alarm-threshold register shared by two requesters: the local key front-end (debounced key_flag/key_value) and a remote command source (UART command decoder).
- Arbitrates the two sources.
- Adds long-press auto-repeat to local keys.
- Saturates the grade.
- Drives the registered threshold plus an update strobe to the downstream comparator.

Parameters:
REPEAT_DLY, 50000000, clk cycles a key must stay held after the initial press before auto-repeat begins (0.5 s at 100 MHz).
REPEAT_PER, 10000000, clk cycles between auto-repeat steps (0.1 s at 100 MHz).
GRADE_RST, 9, grade loaded at reset.
GRADE_MAX, 15, highest legal grade; the lowest is 0.
STEP, 10, threshold increment per grade; threshold = (grade+1)*STEP.

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  reset, synchronous, active-high
key_flag  in  1  one-cycle pulse: debounced key press
key_value  in  2  01 = down, 10 = up; 00/11 ignored
key_hold  in  1  level: the pressed key is still held
rem_valid  in  1  remote request valid
rem_grade  in  4  remote absolute grade request
rem_ready  out  1  controller can accept a remote request this cycle
thr_grade  out  4  current grade
threshold  out  8  current threshold
thr_upd  out  1  one-cycle pulse: threshold changed this cycle

Behaviour:
Reset (rst high at posedge clk, any state, mid-repeat included):
- thr_grade = GRADE_RST, threshold = (GRADE_RST+1)*STEP (100 with defaults).
- state = IDLE, counter = 0, thr_upd = 0, rem_ready = 1.

FSM states:
- IDLE
  - key_flag with a valid key_value: apply one step, go to HOLD_DLY, counter cleared.
  - key_flag with 00/11: no step, stay in IDLE.
- HOLD_DLY
  - counter increments each cycle.
  - key_hold low: go to IDLE.
  - counter == REPEAT_DLY-1: apply one step, go to REPEAT, counter cleared.
- REPEAT
  - key_hold low: go to IDLE.
  - counter == REPEAT_PER-1: apply one step, counter cleared.
- Direction for repeats is latched from key_value at the initial press.
- key_hold low takes priority over a step in the same cycle: no step, go to IDLE.
- key_flag arriving in HOLD_DLY/REPEAT is treated as a fresh press: apply its step, re-latch direction, go to HOLD_DLY, counter cleared.

Step:
- down: grade-1, saturating at 0.
- up: grade+1, saturating at GRADE_MAX.
- At a bound: grade unchanged, no thr_upd, FSM continues normally.

Remote:
- rem_ready = 1 only in IDLE, and is 0 in any cycle where key_flag is high (local has priority).
- Accept when rem_valid & rem_ready: grade = min(rem_grade, GRADE_MAX).
- Accept is a single-cycle handshake; the requester holds rem_valid until accepted.

Latency and widths:
- thr_grade updates at the clock edge after the accepted event.
- threshold and thr_upd update one cycle later, registered from thr_grade.
- thr_upd = 1 iff the new threshold differs from the previous value.
- Threshold arithmetic is 8-bit. Legal parameters satisfy (GRADE_MAX+1)*STEP <= 255; the width does not wrap for legal parameters.
- Counters are 26 bits minimum, sized from the larger of REPEAT_DLY and REPEAT_PER.

Test Plan:
(bench parameters: REPEAT_DLY=8, REPEAT_PER=4, defaults otherwise)
1. Reset: rst high 2 cycles → thr_grade=9, threshold=100, rem_ready=1, thr_upd=0; assert rst mid-REPEAT → same values, state IDLE.
2. Single up press, key_hold dropped after 3 cycles → thr_grade=10 one cycle after key_flag, threshold=110 plus one thr_upd pulse the next cycle; no further steps.
3. Up press, key_hold held for 20 cycles → steps at press, press+8, +12, +16, +20 if held → grade 9→10→11→12→13; stops within 1 cycle of key_hold low.
4. Saturation: grade 15, hold up key 30 cycles → grade stays 15, threshold stays 160, no thr_upd; same check at grade 0 with down key (threshold 10).
5. Remote: rem_valid with rem_grade=3 in IDLE → accepted, grade 3, threshold 40. rem_grade=14 while in REPEAT → rem_ready=0, held until key released, then grade 14. rem_grade=15 while at 15 → accepted, no thr_upd.
6. Simultaneous key_flag(down) and rem_valid(grade 2) at grade 9 → key wins, grade 8, rem_ready=0 that cycle; remote is not applied until the FSM returns to IDLE.
